spi_master_sequencer: RTL and testbench

Command/response sequencer directly upstream of the SPI master device. Buffers outgoing words in a small command FIFO, drives the master's `ENA`/`DATA_MOSI` one frame at a time and waits for `FIN`. Once the master's receive register has settled, it captures `DATA_MISO` into a held response register with valid/ready handshake. Enforces a minimum chip-select-high gap between frames so the master's bit counters re-arm, and aborts frames whose `FIN` never arrives.

---
 rtl/spi_master_sequencer.sv | 116 +++++++++++
 tb/tb_spi_master_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_sequencer.sv
// Command/response sequencer in front of an SPI master: queues outgoing words,
// runs one ENA-framed transfer at a time, captures the MISO word and enforces an inter-frame gap.
module spi_master_sequencer #(
  parameter int outBits = 16,
  parameter int DEPTH   = 4,
  parameter int GAP     = 4,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                     SYS_CLK,
  input  logic                     RESET,
  input  logic [outBits-1:0]       CMD_DATA,
  input  logic                     CMD_VALID,
  output logic                     CMD_READY,
  output logic [outBits-1:0]       RSP_DATA,
  output logic                     RSP_VALID,
  input  logic                     RSP_READY,
  output logic                     ENA,
  output logic [outBits-1:0]       DATA_MOSI,
  input  logic                     FIN,
  input  logic [outBits-1:0]       DATA_MISO,
  output logic                     BUSY,
  output logic                     ERR_TIMEOUT,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] TO_LAST     = 16'(TIMEOUT - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
  localparam logic [15:0] GAP_LAST    = 16'(GAP - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ACTIVE, S_SETTLE, S_GAP} state_t;

  state_t             state, state_next;
  logic [15:0]        timer;
  logic [outBits-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               push, pop, abort, capture;

  assign CMD_READY = (count != CW'(DEPTH));
  assign COUNT     = count;
  assign push      = CMD_VALID && CMD_READY;
  // A new frame is only launched once the previous response has been taken.
  assign pop       = (state == S_IDLE) && (count != '0) && !RSP_VALID;
  assign abort     = (state == S_ACTIVE) && !FIN && (timer == TO_LAST);
  assign capture   = (state == S_SETTLE) && (timer == SETTLE_LAST);

  // NOTE: the storage array has no reset; emptiness is defined by the pointers and count alone.
  always_ff @(posedge SYS_CLK) begin
    if (push) mem[wr_ptr] <= CMD_DATA;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (pop) state_next = S_LOAD;
      S_LOAD:   state_next = S_ACTIVE;
      S_ACTIVE: begin
        if (FIN)                   state_next = S_SETTLE;
        else if (timer == TO_LAST) state_next = S_GAP;
      end
      S_SETTLE: if (timer == SETTLE_LAST) state_next = S_GAP;
      S_GAP:    if (timer == GAP_LAST)    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // ENA decoded from state so it drops together with the asynchronous reset.
  always_comb begin
    ENA  = (state == S_ACTIVE) || (state == S_SETTLE);
    BUSY = (state != S_IDLE);
  end

  // Timer restarts on every state change and runs while a state is held.
  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      timer       <= '0;
      DATA_MOSI   <= '0;
      RSP_DATA    <= '0;
      RSP_VALID   <= 1'b0;
      ERR_TIMEOUT <= 1'b0;
    end else begin
      timer       <= (state_next != state || state == S_IDLE) ? '0 : timer + 16'd1;
      ERR_TIMEOUT <= abort;
      if (pop) DATA_MOSI <= mem[rd_ptr];
      if (capture) begin
        RSP_DATA  <= DATA_MISO;
        RSP_VALID <= 1'b1;
      end else if (RSP_VALID && RSP_READY) begin
        RSP_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Self-checking bench for spi_master_sequencer: behavioural SPI slave/master stand-in,
// frame/response scoreboard queues, a vector table and hand-written corner sequences.
module tb_spi_master_sequencer;

  localparam int OB      = 16;
  localparam int DEPTH   = 4;
  localparam int GAP     = 4;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 1023;
  localparam int FRAME   = 2 * OB + 2;

  logic          SYS_CLK = 1'b0;
  logic          RESET;
  logic [OB-1:0] CMD_DATA;
  logic          CMD_VALID;
  logic          CMD_READY;
  logic [OB-1:0] RSP_DATA;
  logic          RSP_VALID;
  logic          RSP_READY;
  logic          ENA;
  logic [OB-1:0] DATA_MOSI;
  logic          FIN;
  logic [OB-1:0] DATA_MISO;
  logic          BUSY;
  logic          ERR_TIMEOUT;
  logic [2:0]    COUNT;

  spi_master_sequencer #(
    .outBits(OB), .DEPTH(DEPTH), .GAP(GAP), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .SYS_CLK(SYS_CLK), .RESET(RESET),
    .CMD_DATA(CMD_DATA), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .RSP_DATA(RSP_DATA), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .ENA(ENA), .DATA_MOSI(DATA_MOSI), .FIN(FIN), .DATA_MISO(DATA_MISO),
    .BUSY(BUSY), .ERR_TIMEOUT(ERR_TIMEOUT), .COUNT(COUNT)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  typedef struct {
    logic [OB-1:0] cmd;
    logic          timeout;
  } frame_t;

  typedef struct {
    logic [OB-1:0] cmd;
    logic [OB-1:0] rsp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  frame_t        exp_frames[$];
  logic [OB-1:0] exp_rsp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [OB-1:0] nibrev(input logic [OB-1:0] w);
    return {w[3:0], w[7:4], w[11:8], w[15:12]};
  endfunction

  always @(posedge SYS_CLK) cyc++;

  // Master stand-in: FIN rises FRAME cycles into ENA and holds until ENA drops.
  logic fin_dead = 1'b0;
  int   scnt = 0;
  always @(posedge SYS_CLK or posedge RESET) begin
    #1;
    if (RESET || !ENA) begin
      FIN  = 1'b0;
      scnt = 0;
    end else begin
      scnt++;
      if (scnt == FRAME && !fin_dead) begin
        DATA_MISO = nibrev(DATA_MOSI);
        FIN       = 1'b1;
      end
    end
  end

  // Monitor: frame order, MOSI stability, gap, latencies, responses.
  logic   ena_q = 1'b0, rsp_q = 1'b0, have_prev = 1'b0;
  int     low_cnt = 0, ena_time = 0, fin_time = -1;
  int     frames = 0, rsp_rises = 0, errs_seen = 0;
  frame_t cur = '{cmd: '0, timeout: 1'b0};

  always @(negedge SYS_CLK) begin
    if (RESET) begin
      ena_q = 1'b0; rsp_q = 1'b0; have_prev = 1'b0;
    end else begin
      if (ENA && !ena_q) begin
        frames++;
        check("frame_expected", exp_frames.size() != 0, 1'b1);
        if (exp_frames.size() != 0) cur = exp_frames.pop_front();
        check("mosi_frame_start", DATA_MOSI, cur.cmd);
        if (have_prev) check("gap_low_cycles", low_cnt >= GAP + 2, 1'b1);
        ena_time = cyc;
        fin_time = -1;
      end else if (ENA) begin
        check("mosi_stable", DATA_MOSI, cur.cmd);
      end
      if (ENA && FIN && fin_time < 0) fin_time = cyc;
      if (!ENA) begin
        if (ena_q) begin low_cnt = 0; have_prev = 1'b1; end
        low_cnt++;
      end
      if (RSP_VALID && !rsp_q) begin
        rsp_rises++;
        check("rsp_latency", cyc - ena_time, (fin_time - ena_time) + SETTLE + 1);
      end
      if (ERR_TIMEOUT) begin
        errs_seen++;
        check("timeout_delay", cyc - ena_time, TIMEOUT);
        check("timeout_expected", cur.timeout, 1'b1);
      end
      if (RSP_VALID && RSP_READY) begin
        check("rsp_expected", exp_rsp.size() != 0, 1'b1);
        if (exp_rsp.size() != 0) check("rsp_data", RSP_DATA, exp_rsp.pop_front());
      end
      ena_q = ENA;
      rsp_q = RSP_VALID;
    end
  end

  // Stimulus is driven 1 time unit after the rising edge.
  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic push_cmd(input logic [OB-1:0] d, input logic [OB-1:0] r, input logic to,
                          output logic acc);
    CMD_DATA  = d;
    CMD_VALID = 1'b1;
    acc       = CMD_READY;
    if (acc) begin
      exp_frames.push_back('{cmd: d, timeout: to});
      if (!to) exp_rsp.push_back(r);
    end
    tick();
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    logic done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      tick();
      done = !BUSY && COUNT == 0 && !RSP_VALID && exp_rsp.size() == 0 && exp_frames.size() == 0;
    end
    check(name, done, 1'b1);
  endtask

  task automatic wait_ena(input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = ENA;
    end
    check(name, seen, 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ena"},       ENA,         1'b0);
    check({tag, "_mosi"},      DATA_MOSI,   '0);
    check({tag, "_rsp_data"},  RSP_DATA,    '0);
    check({tag, "_rsp_valid"}, RSP_VALID,   1'b0);
    check({tag, "_err"},       ERR_TIMEOUT, 1'b0);
    check({tag, "_busy"},      BUSY,        1'b0);
    check({tag, "_count"},     COUNT,       3'd0);
    check({tag, "_cmd_ready"}, CMD_READY,   1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    logic acc;
    logic acc_fill[5];
    logic started;
    int   f0, r0;

    vecs[0] = '{cmd: 16'hA5C3, rsp: 16'h3C5A};
    vecs[1] = '{cmd: 16'h0000, rsp: 16'h0000};
    vecs[2] = '{cmd: 16'hFFFF, rsp: 16'hFFFF};
    vecs[3] = '{cmd: 16'h1234, rsp: 16'h4321};
    vecs[4] = '{cmd: 16'h8001, rsp: 16'h1008};
    vecs[5] = '{cmd: 16'h0F0F, rsp: 16'hF0F0};
    vecs[6] = '{cmd: 16'hBEEF, rsp: 16'hFEEB};

    RESET = 1'b1; CMD_DATA = '0; CMD_VALID = 1'b0; RSP_READY = 1'b1;
    DATA_MISO = '0; FIN = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset_hold");
    RESET = 1'b0;
    tick();
    check_reset_vals("reset_release");

    // Push-to-ENA timing from an idle, empty sequencer.
    push_cmd(16'hA5C3, 16'h3C5A, 1'b0, acc);
    check("first_accept", acc, 1'b1);
    check("t1_count", COUNT, 3'd1);
    check("t1_busy", BUSY, 1'b0);
    tick();
    check("t2_count", COUNT, 3'd0);
    check("t2_load_busy", BUSY, 1'b1);
    check("t2_ena", ENA, 1'b0);
    tick();
    check("t3_ena", ENA, 1'b1);
    check("t3_mosi", DATA_MOSI, 16'hA5C3);
    wait_drain("single_drain", 200);

    // Vector table: one frame each, responses compared by the monitor.
    for (int i = 0; i < 7; i++) begin
      push_cmd(vecs[i].cmd, vecs[i].rsp, 1'b0, acc);
      check("vec_accept", acc, 1'b1);
      wait_drain("vec_drain", 200);
    end

    // Fill: one frame in flight, then 5 back-to-back pushes.
    push_cmd(16'h1357, nibrev(16'h1357), 1'b0, acc);
    wait_ena("fill_ena");
    for (int i = 0; i < 5; i++) begin
      logic [OB-1:0] w;
      w = 16'h0102 + OB'(i * 16'h1111);
      push_cmd(w, nibrev(w), 1'b0, acc_fill[i]);
    end
    for (int i = 0; i < 4; i++) check("fill_accept", acc_fill[i], 1'b1);
    check("fill_refused", acc_fill[4], 1'b0);
    check("fill_count", COUNT, 3'd4);
    check("fill_not_ready", CMD_READY, 1'b0);
    wait_drain("fill_drain", 1000);

    // Backpressure: first response held, second command waits in the FIFO.
    RSP_READY = 1'b0;
    push_cmd(16'hC001, nibrev(16'hC001), 1'b0, acc);
    push_cmd(16'hC002, nibrev(16'hC002), 1'b0, acc);
    started = 1'b0;
    for (int i = 0; i < 200 && !started; i++) begin
      tick();
      started = RSP_VALID;
    end
    check("bp_rsp_valid_seen", started, 1'b1);
    repeat (GAP + 6) tick();
    check("bp_ena_low", ENA, 1'b0);
    check("bp_count", COUNT, 3'd1);
    check("bp_rsp_held", RSP_VALID, 1'b1);
    check("bp_rsp_data", RSP_DATA, 16'h100C);
    RSP_READY = 1'b1;
    started = 1'b0;
    for (int i = 0; i < 2 && !started; i++) begin
      tick();
      started = BUSY;
    end
    check("bp_restart", started, 1'b1);
    wait_drain("bp_drain", 300);

    // Timeout: FIN never arrives.
    f0 = errs_seen; r0 = rsp_rises;
    fin_dead = 1'b1;
    push_cmd(16'hDEAD, 16'h0000, 1'b1, acc);
    wait_drain("to_drain", TIMEOUT + 100);
    check("to_pulse_count", errs_seen - f0, 1);
    check("to_no_rsp", rsp_rises - r0, 0);
    fin_dead = 1'b0;
    push_cmd(16'h4B1D, 16'hD1B4, 1'b0, acc);
    wait_drain("to_follow_drain", 300);
    check("to_no_extra_pulse", errs_seen - f0, 1);

    // Reset mid-frame with three commands queued.
    for (int i = 0; i < 4; i++) push_cmd(16'h7000 + OB'(i), nibrev(16'h7000 + OB'(i)), 1'b0, acc);
    if (!ENA) wait_ena("rst_ena");
    repeat (5) tick();
    check("rst_pre_count", COUNT, 3'd3);
    #3;
    RESET = 1'b1;
    #1;
    check_reset_vals("reset_mid");
    exp_frames.delete();
    exp_rsp.delete();
    tick();
    RESET = 1'b0;
    f0 = frames; r0 = rsp_rises;
    repeat (200) tick();
    check("rst_no_frames", frames - f0, 0);
    check("rst_no_rsp", rsp_rises - r0, 0);
    check("rst_count", COUNT, 3'd0);

    check("frames_left", exp_frames.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
